// File: rtl/dice_game_pkg.sv
// Shared types and constants for the two-player dice game turn sequencer.
package dice_game_pkg;

    // Encoded game FSM states; the encoding is exported on game_state.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TURN    = 2'd1,
        S_ROLLING = 2'd2,
        S_WIN     = 2'd3
    } game_state_t;

    // Winner encoding
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [6:0] SCORE_MAX      = 7'd127;
    localparam logic [6:0] DEFAULT_TARGET = 7'd100;

    // 7-bit add through an 8-bit intermediate, clamped at SCORE_MAX.
    function automatic logic [6:0] sat_add(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[6:0];
    endfunction

    // Next die face in the 1..6 cycle.
    function automatic logic [2:0] next_face(input logic [2:0] face);
        return (face == 3'd6) ? 3'd1 : face + 3'd1;
    endfunction

endpackage

// File: rtl/dice_turn_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-sample counter, debounced
// level and a one-cycle release pulse. After reset the button is treated as
// pressed and disarmed, so a button held through reset must be released
// (silently) before it can produce any edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_btn,
    output logic o_level,
    output logic o_release
);
    import dice_game_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic          r_armed;
    logic          r_release;
    logic [CW-1:0] r_cnt;

    // Bring the raw asynchronous button into the CLK domain.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_level   <= 1'b1;
            r_armed   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_release <= 1'b0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync1;
                if (!r_sync1) begin
                    r_armed   <= 1'b1;
                    r_release <= r_armed;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level   = r_level & r_armed;
    assign o_release = r_release;

endmodule

// File: rtl/dice_turn_sequencer.sv
// Two-player dice game turn controller: debounced buttons, free-spinning die,
// turn-sum / score banking with saturation, turn hand-over and win detection.
// Optional feature macro: WIN_BLINK_EN (blink the winner LED in S_WIN).
module dice_turn_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 500000,
    parameter int BLINK_DIV       = 25000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       NEW_GAME,
    input  logic       ROLL,
    input  logic       HOLD,
    input  logic [6:0] target,
    output logic [2:0] dice,
    output logic [6:0] turn_sum,
    output logic [6:0] score1,
    output logic [6:0] score2,
    output logic       p1_led,
    output logic       p2_led,
    output logic [1:0] winner,
    output logic [1:0] game_state
);
    import dice_game_pkg::*;

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic w_new_level, w_new_rel;
    logic w_roll_level, w_roll_rel;
    logic w_hold_level, w_hold_rel;
    logic w_roll_rise;
    logic [6:0] w_bank;

    game_state_t   r_state,    w_state_next;
    logic [2:0]    r_dice,     w_dice_next;
    logic [6:0]    r_turn_sum, w_turn_sum_next;
    logic [6:0]    r_score1,   w_score1_next;
    logic [6:0]    r_score2,   w_score2_next;
    logic [1:0]    r_winner,   w_winner_next;
    logic          r_active,   w_active_next;   // 0 = P1, 1 = P2
    logic [6:0]    r_target,   w_target_next;
    logic [TW-1:0] r_tick_cnt, w_tick_next;
    logic          r_p1_led,   w_p1_led_next;
    logic          r_p2_led,   w_p2_led_next;
    logic          r_roll_level_d;
    logic          w_win_blink_on;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_new_db (
        .CLK(CLK), .RESET(RESET), .i_btn(NEW_GAME),
        .o_level(w_new_level), .o_release(w_new_rel)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_roll_db (
        .CLK(CLK), .RESET(RESET), .i_btn(ROLL),
        .o_level(w_roll_level), .o_release(w_roll_rel)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold_db (
        .CLK(CLK), .RESET(RESET), .i_btn(HOLD),
        .o_level(w_hold_level), .o_release(w_hold_rel)
    );

    // A roll starts on the debounced ROLL press, and only while NEW_GAME and
    // HOLD are idle, so the higher-priority buttons always win a tie.
    assign w_roll_rise = w_roll_level & ~r_roll_level_d & ~w_new_level & ~w_hold_level;

    // Active player's score with the current turn banked into it.
    assign w_bank = sat_add(r_active ? r_score2 : r_score1, r_turn_sum);

    // Track the previous debounced ROLL level for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) r_roll_level_d <= 1'b0;
        else       r_roll_level_d <= w_roll_level;
    end

    // Next-state and datapath decisions; NEW_GAME > HOLD > ROLL.
    always_comb begin
        w_state_next    = r_state;
        w_dice_next     = r_dice;
        w_turn_sum_next = r_turn_sum;
        w_score1_next   = r_score1;
        w_score2_next   = r_score2;
        w_winner_next   = r_winner;
        w_active_next   = r_active;
        w_target_next   = r_target;
        w_tick_next     = r_tick_cnt;
        if (w_new_rel) begin
            w_state_next    = S_TURN;
            w_dice_next     = 3'd0;
            w_turn_sum_next = 7'd0;
            w_score1_next   = 7'd0;
            w_score2_next   = 7'd0;
            w_winner_next   = WIN_NONE;
            w_tick_next     = '0;
            w_target_next   = (target == 7'd0) ? DEFAULT_TARGET : target;
            // Loser of a finished game starts; otherwise P1 starts.
            w_active_next   = (r_state == S_WIN) && (r_winner == WIN_P1);
        end else begin
            case (r_state)
                S_TURN: begin
                    if (w_hold_rel) begin
                        if (r_active) w_score2_next = w_bank;
                        else          w_score1_next = w_bank;
                        w_turn_sum_next = 7'd0;
                        if (w_bank >= r_target) begin
                            w_state_next  = S_WIN;
                            w_winner_next = r_active ? WIN_P2 : WIN_P1;
                        end else begin
                            w_active_next = ~r_active;
                        end
                    end else if (w_roll_rise) begin
                        w_state_next = S_ROLLING;
                        w_dice_next  = 3'd1;
                        w_tick_next  = '0;
                    end
                end
                S_ROLLING: begin
                    if (w_roll_rel) begin
                        w_state_next = S_TURN;
                        if (r_dice == 3'd1) begin
                            w_turn_sum_next = 7'd0;
                            w_active_next   = ~r_active;
                        end else begin
                            w_turn_sum_next = sat_add(r_turn_sum, {4'd0, r_dice});
                        end
                    end else if (w_roll_level) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            w_tick_next = '0;
                            w_dice_next = next_face(r_dice);
                        end else begin
                            w_tick_next = r_tick_cnt + TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WIN_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt, w_blink_cnt_next;
    logic          r_blink_phase, w_blink_phase_next;

    // Blink divider: restarts (LED on) on entry to S_WIN, toggles every BLINK_DIV.
    always_comb begin
        w_blink_cnt_next   = r_blink_cnt;
        w_blink_phase_next = r_blink_phase;
        if (w_state_next == S_WIN) begin
            if (r_state != S_WIN) begin
                w_blink_cnt_next   = '0;
                w_blink_phase_next = 1'b1;
            end else if (r_blink_cnt == BLINK_LAST) begin
                w_blink_cnt_next   = '0;
                w_blink_phase_next = ~r_blink_phase;
            end else begin
                w_blink_cnt_next = r_blink_cnt + BW'(1);
            end
        end
    end

    // Blink divider registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_blink_cnt   <= w_blink_cnt_next;
            r_blink_phase <= w_blink_phase_next;
        end
    end

    assign w_win_blink_on = w_blink_phase_next;
`else
    assign w_win_blink_on = 1'b1;
`endif

    // LED selection: active player normally, winner (steady or blinking) in S_WIN.
    always_comb begin
        w_p1_led_next = ~w_active_next;
        w_p2_led_next = w_active_next;
        if (w_state_next == S_WIN) begin
            w_p1_led_next = (w_winner_next == WIN_P1) & w_win_blink_on;
            w_p2_led_next = (w_winner_next == WIN_P2) & w_win_blink_on;
        end
    end

    // Game state and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_dice     <= 3'd0;
            r_turn_sum <= 7'd0;
            r_score1   <= 7'd0;
            r_score2   <= 7'd0;
            r_winner   <= WIN_NONE;
            r_active   <= 1'b0;
            r_target   <= DEFAULT_TARGET;
            r_tick_cnt <= '0;
            r_p1_led   <= 1'b1;
            r_p2_led   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dice     <= w_dice_next;
            r_turn_sum <= w_turn_sum_next;
            r_score1   <= w_score1_next;
            r_score2   <= w_score2_next;
            r_winner   <= w_winner_next;
            r_active   <= w_active_next;
            r_target   <= w_target_next;
            r_tick_cnt <= w_tick_next;
            r_p1_led   <= w_p1_led_next;
            r_p2_led   <= w_p2_led_next;
        end
    end

    assign game_state = r_state;
    assign dice       = r_dice;
    assign turn_sum   = r_turn_sum;
    assign score1     = r_score1;
    assign score2     = r_score2;
    assign winner     = r_winner;
    assign p1_led     = r_p1_led;
    assign p2_led     = r_p2_led;

endmodule
